// File: rtl/leds_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : leds_sequencer
// Brief   : Debounced two-button control of a 4-bit up/down/pause LED counter.
// Revision: 1.0
// ============================================================================
module leds_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BTN1,
    input  logic       BTN2,
    output logic [3:0] leds,
    output logic [1:0] state,
    output logic       busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int ST_W = $clog2(STEP_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        UP    = 2'b01,
        DOWN  = 2'b10,
        PAUSE = 2'b11
    } state_e;

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {BTN2, BTN1};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic            s1_q;
        logic            s2_q;
        logic            db_q;
        logic            db_dly_q;
        logic [DB_W-1:0] cnt_q;

        // A new level is accepted only after DEBOUNCE_CYCLES unbroken cycles of disagreement.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                db_q     <= 1'b0;
                db_dly_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                s1_q     <= btn_raw[i];
                s2_q     <= s1_q;
                db_dly_q <= db_q;
                if (s2_q == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    db_q  <= s2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign press[i] = db_q & ~db_dly_q;
    end

    state_e          state_q;
    logic [3:0]      leds_q;
    logic            busy_q;
    logic [ST_W-1:0] tcnt_q;
    logic            tick;

    assign tick = ((state_q == UP) || (state_q == DOWN)) && (tcnt_q == ST_LAST);

    // Press events take priority over a pending step and restart the step timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            leds_q  <= 4'd0;
            busy_q  <= 1'b0;
            tcnt_q  <= '0;
        end else if (press[0] && press[1]) begin
            state_q <= IDLE;
            leds_q  <= 4'd0;
            busy_q  <= 1'b0;
            tcnt_q  <= '0;
        end else if (press[0]) begin
            state_q <= (state_q == UP) ? PAUSE : UP;
            busy_q  <= (state_q != UP);
            tcnt_q  <= '0;
        end else if (press[1]) begin
            state_q <= (state_q == DOWN) ? PAUSE : DOWN;
            busy_q  <= (state_q != DOWN);
            tcnt_q  <= '0;
        end else begin
            case (state_q)
                UP: begin
                    tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
                    if (tick) begin
                        leds_q <= leds_q + 4'd1;
                    end
                end
                DOWN: begin
                    tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
                    if (tick) begin
                        leds_q <= leds_q - 4'd1;
                    end
                end
                IDLE: begin
                    tcnt_q <= '0;
                    leds_q <= 4'd0;
                end
                default: begin
                    tcnt_q <= '0;
                end
            endcase
        end
    end

    assign leds  = leds_q;
    assign state = state_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: doc/leds_sequencer.md
# leds_sequencer

Control block that sequences the 4-LED display from the two board push-buttons. It synchronizes and debounces raw BTN1/BTN2, turns debounced presses into one-cycle events, and runs a four-state FSM that counts the LED value up, counts it down, pauses it or clears it at a programmable step rate. It sits between the button pins and `leds` in the FPGA top level and owns every write to the LED register.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a synchronized level must differ from the accepted level before it is taken. Range 2..2^20. Set to 4 for simulation and 500000 for the board.
- `STEP_CYCLES`, 8: cycles between LED updates while counting. Range 2..2^24.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `BTN1`  in  1  raw button, asynchronous, may bounce. High means pressed.
- `BTN2`  in  1  raw button, asynchronous, may bounce. High means pressed.
- `leds`  out  4  registered LED value.
- `state`  out  2  FSM state: IDLE=00, UP=01, DOWN=10, PAUSE=11.
- `busy`  out  1  high in UP or DOWN.

## Operation
- **Synchronizer:** two flops per button (`s1`, `s2`); both reset to 0.
- **Debouncer, per button:** accepted level `db` (reset 0) and counter `cnt` (reset 0).
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any return of `s2` to `db` before acceptance discards the attempt.
- **Press event:** `pressN = db & ~db_d`, where `db_d` is `db` delayed by one cycle. It is high for exactly one cycle per accepted press. Releases generate no event.
- **FSM transitions:** "both" means `press1` and `press2` are high in the same cycle.
  - IDLE: `press1` → UP; `press2` → DOWN; both → IDLE.
  - UP: `press1` → PAUSE; `press2` → DOWN; both → IDLE.
  - DOWN: `press2` → PAUSE; `press1` → UP; both → IDLE.
  - PAUSE: `press1` → UP; `press2` → DOWN; both → IDLE.
- **Entering IDLE:** `leds <= 0` on the same edge, including IDLE → IDLE.
- **Step timer:** `tcnt`, reset 0.
  - Counts only in UP or DOWN, 0..STEP_CYCLES-1, then wraps.
  - `tick` = (`tcnt == STEP_CYCLES-1`) in UP or DOWN.
  - Cleared to 0 on every edge where a press event is present, and while in IDLE or PAUSE.
- **Datapath:**
  - UP and `tick`: `leds <= leds+1`, mod 16 (1111 → 0000).
  - DOWN and `tick`: `leds <= leds-1`, mod 16 (0000 → 1111).
  - PAUSE holds `leds`.
  - UP/DOWN/PAUSE transitions keep the current value.
- **Priority:** a press event wins over `tick` in the same cycle. No step is taken on that edge.

## Timing
- **Reset values:** `leds=0000`, `state=00`, `busy=0`, all internal registers 0. Reset takes effect immediately on `rst_n` falling, without waiting for `clk`.
- **Reset release:** first state change is possible on the first `clk` rising edge with `rst_n=1`.
- **Reset mid-operation:** any count and any pending debounce are discarded. A button held through reset release is accepted as a new press after the normal latency.
- **Press latency:** button high and stable, first sampled into `s1` at edge k.
  - `s2=1` at edge k+1.
  - `db=1` at edge k+DEBOUNCE_CYCLES+1.
  - `press` is high during the following cycle.
  - `state` and `busy` update at edge k+DEBOUNCE_CYCLES+2.
- **Glitch rejection:** pulses on `s2` shorter than DEBOUNCE_CYCLES cycles never change `db`. Release follows the same rule.
- **Step timing:** after entering UP or DOWN at edge e, the first LED step is at edge e+STEP_CYCLES. Further steps follow every STEP_CYCLES edges.
- **Button timing:** the two buttons are debounced independently. "Both" requires their `press` pulses to coincide exactly. Presses one cycle apart are two separate events.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, STEP_CYCLES=8.

1. **Reset:** `rst_n` low for 3 cycles with buttons toggling → `leds=0000`, `state=00`, `busy=0` throughout; no change for 10 cycles after release with buttons low.
2. **Count up:** clean BTN1 press → `state=01` exactly 6 edges after first sample. Then `leds` reads 1, 2, 3 at +8, +16, +24 edges, and wraps 1111 → 0000 on the 16th step.
3. **Count down and pause:** from IDLE, BTN2 press → DOWN; first step gives `leds=1111`. Second BTN2 press → `state=11`, `leds` frozen for 50 cycles. BTN1 → UP resumes from the frozen value.
4. **Bounce:** BTN1 toggles with high/low runs of 1-3 cycles for 30 cycles, then stays high → exactly one `press1` pulse and one transition. Bounce on release produces no event.
5. **Simultaneous press:** BTN1 and BTN2 rise on the same edge while UP with `leds=0101` → `state=00`, `leds=0000`. Same pair from IDLE → stays IDLE.
6. **Press vs tick:** press `press2` so it coincides with `tcnt=7` in UP → `state=10`, no step on that edge, first down-step 8 edges later. Also assert `rst_n` mid-count → outputs 0 immediately, asynchronously.
